// File: rtl/noc_packet_receiver.sv
// Ejection-side network interface: parses head/body/tail flits from the router local port,
// checks the destination and delivers tagged payload words through a small FWFT FIFO.
module noc_packet_receiver #(
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int NODE_ID     = 0,
    parameter int FIFO_DEPTH  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  flit_in_data,
    input  logic                   flit_in_valid,
    output logic                   flit_in_ready,
    output logic [DATA_WIDTH-3:0]  payload_out_data,
    output logic [ID_WIDTH-1:0]    payload_out_src,
    output logic                   payload_out_last,
    output logic                   payload_out_abort,
    output logic                   payload_out_valid,
    input  logic                   payload_out_ready,
    output logic                   pkt_done,
    output logic                   err_framing,
    output logic                   err_misroute,
    output logic [COUNT_WIDTH-1:0] pkt_count,
    output logic [COUNT_WIDTH-1:0] err_count,
    output logic [1:0]             fsm_state
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int PAY_W   = DATA_WIDTH - 2;
    localparam int ENTRY_W = PAY_W + ID_WIDTH + 2;
    localparam logic [CNT_W-1:0]    FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ID_WIDTH-1:0] MY_ID      = ID_WIDTH'(NODE_ID);
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_BODY = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    // fsm_state encoding: 0 = IDLE, 1 = BODY, 2 = DROP
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BODY = 2'd1, S_DROP = 2'd2} state_t;

    state_t                r_state, w_next;
    logic [ID_WIDTH-1:0]   r_src;
    logic [ENTRY_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_pkt_done, r_err_framing, r_err_misroute;
    logic [COUNT_WIDTH-1:0] r_pkt_count, r_err_count;

    logic [1:0]            w_type;
    logic [ID_WIDTH-1:0]   w_dest, w_src;
    logic                  w_accept, w_full, w_pop;
    logic                  w_push, w_push_last, w_push_abort;
    logic [PAY_W-1:0]      w_push_data;
    logic                  w_set_done, w_set_frm, w_set_mis, w_latch_src;
    logic [ENTRY_W-1:0]    w_head;

    assign w_type   = flit_in_data[DATA_WIDTH-1:DATA_WIDTH-2];
    assign w_dest   = flit_in_data[ID_WIDTH-1:0];
    assign w_src    = flit_in_data[2*ID_WIDTH-1:ID_WIDTH];
    assign w_full   = (r_count == FULL_COUNT);
    // Ready looks only at registered state, so a pop this cycle does not free a slot until next cycle.
    assign flit_in_ready = (r_state != S_BODY) || !w_full;
    assign w_accept = flit_in_valid && flit_in_ready;
    assign w_pop    = payload_out_valid && payload_out_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_accept) begin
            case (r_state)
                S_IDLE: if (w_type == T_HEAD) w_next = (w_dest == MY_ID) ? S_BODY : S_DROP;
                S_BODY: begin
                    if (w_type == T_TAIL)      w_next = S_IDLE;
                    else if (w_type == T_HEAD) w_next = S_DROP;
                end
                S_DROP: if (w_type == T_TAIL) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_push       = 1'b0;
        w_push_data  = '0;
        w_push_last  = 1'b0;
        w_push_abort = 1'b0;
        w_set_done   = 1'b0;
        w_set_frm    = 1'b0;
        w_set_mis    = 1'b0;
        w_latch_src  = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (w_type == T_HEAD) begin
                        if (w_dest == MY_ID) w_latch_src = 1'b1;
                        else                 w_set_mis   = 1'b1;
                    end else begin
                        w_set_frm = 1'b1;
                    end
                end
                S_BODY: begin
                    case (w_type)
                        T_BODY: begin
                            w_push      = 1'b1;
                            w_push_data = flit_in_data[PAY_W-1:0];
                        end
                        T_TAIL: begin
                            w_push      = 1'b1;
                            w_push_data = flit_in_data[PAY_W-1:0];
                            w_push_last = 1'b1;
                            w_set_done  = 1'b1;
                        end
                        // A head inside a packet closes the open packet with an abort marker.
                        T_HEAD: begin
                            w_push       = 1'b1;
                            w_push_last  = 1'b1;
                            w_push_abort = 1'b1;
                            w_set_frm    = 1'b1;
                        end
                        default: w_set_frm = 1'b1;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src          <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_pkt_done     <= 1'b0;
            r_err_framing  <= 1'b0;
            r_err_misroute <= 1'b0;
            r_pkt_count    <= '0;
            r_err_count    <= '0;
        end else begin
            if (w_latch_src) r_src <= w_src;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
            r_pkt_done     <= w_set_done;
            r_err_framing  <= w_set_frm;
            r_err_misroute <= w_set_mis;
            if (w_set_done && (r_pkt_count != '1))
                r_pkt_count <= r_pkt_count + COUNT_WIDTH'(1);
            if ((w_set_frm || w_set_mis) && (r_err_count != '1))
                r_err_count <= r_err_count + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_push_data, r_src, w_push_last, w_push_abort};
    end

    // Storage is not reset, so the head entry is masked while the FIFO is empty.
    assign payload_out_valid = (r_count != '0);
    assign w_head            = payload_out_valid ? r_mem[r_rd_ptr] : '0;
    assign payload_out_data  = w_head[ENTRY_W-1:ID_WIDTH+2];
    assign payload_out_src   = w_head[ID_WIDTH+1:2];
    assign payload_out_last  = w_head[1];
    assign payload_out_abort = w_head[0];

    assign pkt_done     = r_pkt_done;
    assign err_framing  = r_err_framing;
    assign err_misroute = r_err_misroute;
    assign pkt_count    = r_pkt_count;
    assign err_count    = r_err_count;
    assign fsm_state    = r_state;

endmodule

// File: tb/tb_noc_packet_receiver.sv
// Self-checking bench for noc_packet_receiver: directed packet scenarios followed by
// random flit traffic, all compared against a packet-level reference model.
module tb_noc_packet_receiver;
  localparam int DW    = 32;
  localparam int IDW   = 4;
  localparam int NODE  = 7;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int EW    = DW - 2 + IDW + 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   flit_in_data = '0;
  logic            flit_in_valid = 1'b0;
  logic            flit_in_ready;
  logic [DW-3:0]   payload_out_data;
  logic [IDW-1:0]  payload_out_src;
  logic            payload_out_last, payload_out_abort, payload_out_valid;
  logic            payload_out_ready = 1'b1;
  logic            pkt_done, err_framing, err_misroute;
  logic [CW-1:0]   pkt_count, err_count;
  logic [1:0]      fsm_state;

  noc_packet_receiver #(
    .DATA_WIDTH(DW), .ID_WIDTH(IDW), .NODE_ID(NODE), .FIFO_DEPTH(DEPTH), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .flit_in_data(flit_in_data), .flit_in_valid(flit_in_valid), .flit_in_ready(flit_in_ready),
    .payload_out_data(payload_out_data), .payload_out_src(payload_out_src),
    .payload_out_last(payload_out_last), .payload_out_abort(payload_out_abort),
    .payload_out_valid(payload_out_valid), .payload_out_ready(payload_out_ready),
    .pkt_done(pkt_done), .err_framing(err_framing), .err_misroute(err_misroute),
    .pkt_count(pkt_count), .err_count(err_count), .fsm_state(fsm_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: packet-level view of the receiver
  logic [EW-1:0]  exp_q[$];
  logic           m_in_pkt, m_dropping;
  logic [IDW-1:0] m_src;
  logic           m_done, m_frm, m_mis;
  logic [CW-1:0]  m_pkts, m_errs;

  task automatic model_clear();
    exp_q.delete();
    m_in_pkt = 0; m_dropping = 0; m_src = '0;
    m_done = 0; m_frm = 0; m_mis = 0;
    m_pkts = '0; m_errs = '0;
  endtask

  task automatic model_error(input bit misroute);
    if (misroute) m_mis = 1; else m_frm = 1;
    if (m_errs != {CW{1'b1}}) m_errs = m_errs + 1'b1;
  endtask

  task automatic model_accept(input logic [DW-1:0] f);
    logic [1:0] ty;
    ty = f[DW-1:DW-2];
    if (m_dropping) begin
      if (ty == 2'b11) m_dropping = 0;
    end else if (m_in_pkt) begin
      if (ty == 2'b10) exp_q.push_back({f[DW-3:0], m_src, 1'b0, 1'b0});
      else if (ty == 2'b11) begin
        exp_q.push_back({f[DW-3:0], m_src, 1'b1, 1'b0});
        m_done = 1; m_in_pkt = 0;
        if (m_pkts != {CW{1'b1}}) m_pkts = m_pkts + 1'b1;
      end else if (ty == 2'b01) begin
        exp_q.push_back({{(DW-2){1'b0}}, m_src, 1'b1, 1'b1});
        model_error(0); m_in_pkt = 0; m_dropping = 1;
      end else model_error(0);
    end else begin
      if (ty == 2'b01) begin
        if (f[IDW-1:0] == IDW'(NODE)) begin m_in_pkt = 1; m_src = f[2*IDW-1:IDW]; end
        else begin model_error(1); m_dropping = 1; end
      end else model_error(0);
    end
  endtask

  function automatic logic [1:0] exp_state();
    return m_dropping ? 2'd2 : (m_in_pkt ? 2'd1 : 2'd0);
  endfunction

  // One clock cycle; called at a negedge with inputs already driven.
  task automatic cycle();
    logic exp_ready, acc, pop;
    logic [EW-1:0] e;
    exp_ready = !(m_in_pkt && exp_q.size() == DEPTH);
    check_eq("flit_in_ready", flit_in_ready, exp_ready);
    check_eq("payload_out_valid", payload_out_valid, exp_q.size() != 0);
    check_eq("fsm_state", fsm_state, exp_state());
    acc = flit_in_valid && exp_ready;
    pop = payload_out_ready && (exp_q.size() != 0);
    if (pop) begin
      e = exp_q.pop_front();
      check_eq("payload_data", payload_out_data, e[EW-1:IDW+2]);
      check_eq("payload_src", payload_out_src, e[IDW+1:2]);
      check_eq("payload_last", payload_out_last, e[1]);
      check_eq("payload_abort", payload_out_abort, e[0]);
    end
    m_done = 0; m_frm = 0; m_mis = 0;
    if (acc) model_accept(flit_in_data);
    @(posedge clk);
    @(negedge clk);
    check_eq("pkt_done", pkt_done, m_done);
    check_eq("err_framing", err_framing, m_frm);
    check_eq("err_misroute", err_misroute, m_mis);
    check_eq("pkt_count", pkt_count, m_pkts);
    check_eq("err_count", err_count, m_errs);
  endtask

  // driver tasks
  task automatic send_flit(input logic [DW-1:0] f);
    logic accepted;
    accepted = 0;
    flit_in_data = f;
    flit_in_valid = 1;
    for (int i = 0; i < 200 && !accepted; i++) begin
      accepted = flit_in_ready;
      cycle();
    end
    check_eq("accept_timeout", accepted, 1'b1);
    flit_in_valid = 0;
  endtask

  task automatic send_packet(input logic [DW-1:0] head, input int nbody, input logic [7:0] base);
    send_flit(head);
    for (int i = 0; i < nbody; i++) send_flit({2'b10, 22'd0, base + 8'(i)});
    send_flit({2'b11, 22'd0, base + 8'(nbody)});
  endtask

  task automatic idle(input int n);
    flit_in_valid = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    flit_in_valid = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_clear();
    check_eq("rst_ready", flit_in_ready, 1'b1);
    check_eq("rst_valid", payload_out_valid, 1'b0);
    check_eq("rst_data", payload_out_data, '0);
    check_eq("rst_src", payload_out_src, '0);
    check_eq("rst_last", payload_out_last, 1'b0);
    check_eq("rst_abort", payload_out_abort, 1'b0);
    check_eq("rst_pulses", {pkt_done, err_framing, err_misroute}, 3'b000);
    check_eq("rst_pkt_count", pkt_count, '0);
    check_eq("rst_err_count", err_count, '0);
    check_eq("rst_state", fsm_state, 2'd0);
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    do_reset(2);

    // 1: clean packet, core always ready
    payload_out_ready = 1;
    send_flit(32'h40000007);
    send_flit(32'h80000012); send_flit(32'h80000013);
    send_flit(32'h80000014); send_flit(32'h80000015);
    send_flit(32'hC0000016);
    idle(3);
    check_eq("t1_pkt_count", pkt_count, 3'd1);

    // 2: backpressure, FIFO fills and the tail stalls
    payload_out_ready = 0;
    send_flit(32'h40000017);
    for (int i = 0; i < 4; i++) send_flit(32'h80000032 + i);
    flit_in_data = 32'hC0000036;
    flit_in_valid = 1;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("t2_stall_ready", flit_in_ready, 1'b0);
    payload_out_ready = 1;
    send_flit(32'hC0000036);
    idle(8);
    check_eq("t2_drained", exp_q.size(), 0);

    // 3: misrouted packet is dropped, next good packet delivered
    send_packet(32'h40000015, 4, 8'h40);
    idle(2);
    send_packet(32'h40000027, 2, 8'h50);
    idle(4);

    // 4: stray body in IDLE
    send_flit(32'h80000099);
    send_packet(32'h40000037, 1, 8'h60);
    idle(4);

    // 5: head inside a packet aborts it
    send_flit(32'h40000087);
    send_flit(32'h80000001); send_flit(32'h80000002);
    send_flit(32'h40000097);
    send_flit(32'h80000003);
    send_flit(32'hC0000004);
    idle(6);
    check_eq("t5_err_count", err_count, 3'd3);

    // 6: reset mid-packet with words held in the FIFO
    payload_out_ready = 0;
    send_flit(32'h40000047);
    for (int i = 0; i < 3; i++) send_flit(32'h80000070 + i);
    do_reset(1);
    payload_out_ready = 1;
    send_packet(32'h40000057, 2, 8'h80);
    idle(4);
    check_eq("t6_pkt_count", pkt_count, 3'd1);

    // random traffic; narrow counters saturate along the way
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] ty;
      logic [IDW-1:0] dst;
      ty  = 2'($urandom_range(0, 9) < 1 ? 0 : ($urandom_range(0, 9) < 2 ? 1 : ($urandom_range(0, 3) == 0 ? 3 : 2)));
      dst = ($urandom_range(0, 4) == 0) ? IDW'($urandom_range(0, 15)) : IDW'(NODE);
      flit_in_data = {ty, 22'($urandom), IDW'($urandom_range(0, 15)), dst};
      flit_in_valid = ($urandom_range(0, 3) != 0);
      payload_out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    payload_out_ready = 1;
    idle(10);
    check_eq("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
